// File: rtl/banked_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : banked_mem_responder
// Description : Four-bank word-interleaved main-memory responder. Accepts one
//               rd/wr request per cycle, keeps each bank occupied for
//               BANK_CYCLES cycles and returns read data after a fixed
//               two-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_mem_responder #(
    parameter int ROW_BITS    = 13,
    parameter int BANK_CYCLES = 4,
    parameter int RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int         c_ROWS = 2 ** ROW_BITS;
    localparam logic [2:0] c_LOAD = 3'(BANK_CYCLES - 1);

    logic                w_req;
    logic                w_err;
    logic                w_stall;
    logic                w_accept;
    logic [1:0]          w_bank;
    logic [ROW_BITS-1:0] w_row;
    logic                w_unused;

    logic [15:0] r_mem [4][c_ROWS];
    logic        r_s1_valid;
    logic [15:0] r_s1_data;
    logic        r_data_valid;
    logic [15:0] r_data_out;

    // Address bits above the row field are deliberately ignored (row aliasing).
    assign w_unused = ^addr;
    assign w_bank   = addr[2:1];
    assign w_row    = addr[ROW_BITS+2:3];

    // Request decode: illegal requests never reach the busy check.
    assign w_req    = rd | wr;
    assign w_err    = (rd & wr) | (w_req & addr[0]);
    assign w_stall  = w_req & ~w_err & busy[w_bank];
    assign w_accept = w_req & ~w_err & ~w_stall;

    assign err        = w_err;
    assign stall      = w_stall;
    assign data_valid = r_data_valid;
    assign data_out   = r_data_out;

    // One occupancy down-counter per bank; reload on accept, else count to 0.
    generate
        for (genvar b = 0; b < 4; b++) begin : g_bank
            logic [2:0] r_cnt;

            // Bank occupancy counter.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= 3'd0;
                end else if (w_accept && (w_bank == 2'(b))) begin
                    r_cnt <= c_LOAD;
                end else if (r_cnt != 3'd0) begin
                    r_cnt <= r_cnt - 3'd1;
                end
            end

            assign busy[b] = (r_cnt != 3'd0);
        end
    endgenerate

    // Storage array and read stage 1 data; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && wr && !rst) begin
            r_mem[w_bank][w_row] <= data_in;
        end
        if (w_accept && rd) begin
            r_s1_data <= r_mem[w_bank][w_row];
        end
    end

    // Free-running read return pipeline; data_out is zero whenever not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= 16'h0000;
        end else begin
            r_s1_valid   <= w_accept & rd;
            r_data_valid <= r_s1_valid;
            r_data_out   <= r_s1_valid ? r_s1_data : 16'h0000;
        end
    end

endmodule
`default_nettype wire
